stopwatch_ctrl: RTL and testbench

//  Front-end controller for the stopwatch counter. Turns three raw push-button

---
 rtl/stopwatch_ctrl_if.sv | 27 ++
 rtl/stopwatch_ctrl.sv | 157 +++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_ctrl_if.sv
// Button, counter and display signals between the board/stopwatch side and the controller.
`timescale 1ns/1ps
interface stopwatch_ctrl_if #(
    parameter int unsigned TIME_W = 8
);
    logic              start_stop_i;
    logic              lap_i;
    logic              clear_i;
    logic [TIME_W-1:0] time_i;
    logic              count_o;
    logic              clear_o;
    logic [TIME_W-1:0] disp_o;
    logic              running_o;
    logic              lap_active_o;

    // Board/stopwatch side: drives buttons and counter value, observes controls.
    modport master (
        output start_stop_i, lap_i, clear_i, time_i,
        input  count_o, clear_o, disp_o, running_o, lap_active_o
    );

    // Controller side.
    modport slave (
        input  start_stop_i, lap_i, clear_i, time_i,
        output count_o, clear_o, disp_o, running_o, lap_active_o
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch front-end: button synchronisers, press detection, run/pause/lap FSM
// and a clear sequencer that first arms the counter so it honours the clear.
`timescale 1ns/1ps
module stopwatch_ctrl #(
    parameter int unsigned TIME_W      = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    stopwatch_ctrl_if.slave  bus
);

    localparam int unsigned N_BTN = 3;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RUN      = 3'd1,
        S_PAUSE    = 3'd2,
        S_CLR_ARM  = 3'd3,
        S_CLR_FIRE = 3'd4
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync_ss;
    logic [SYNC_STAGES-1:0] r_sync_lap;
    logic [SYNC_STAGES-1:0] r_sync_clr;
    logic [N_BTN-1:0]       w_synced;   // {clr, lap, ss}
    logic [N_BTN-1:0]       r_prev;
    logic [N_BTN-1:0]       w_rise;
    logic [N_BTN-1:0]       r_pulse;
    logic                   w_do_clr;
    logic                   w_do_ss;
    logic                   w_do_lap;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [TIME_W-1:0]      r_lap_q;
    logic [TIME_W-1:0]      w_lap_q_nxt;
    logic                   r_lap_active;
    logic                   w_lap_active_nxt;
    logic                   r_count;
    logic                   r_clear;
    logic                   r_running;
    logic                   w_count_nxt;
    logic                   w_clear_nxt;
    logic                   w_running_nxt;

    assign w_synced = {r_sync_clr[SYNC_STAGES-1], r_sync_lap[SYNC_STAGES-1],
                       r_sync_ss[SYNC_STAGES-1]};
    assign w_rise   = w_synced & ~r_prev;

    // Synchronise raw buttons, then register a one-cycle pulse per rising level.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_sync_ss  <= '0;
            r_sync_lap <= '0;
            r_sync_clr <= '0;
            r_prev     <= '0;
            r_pulse    <= '0;
        end else begin
            r_sync_ss  <= {r_sync_ss[SYNC_STAGES-2:0],  bus.start_stop_i};
            r_sync_lap <= {r_sync_lap[SYNC_STAGES-2:0], bus.lap_i};
            r_sync_clr <= {r_sync_clr[SYNC_STAGES-2:0], bus.clear_i};
            r_prev     <= w_synced;
            r_pulse    <= w_rise;
        end
    end

    // Resolve simultaneous presses: clear beats start/stop beats lap.
    assign w_do_clr = r_pulse[2];
    assign w_do_ss  = r_pulse[0] & ~r_pulse[2];
    assign w_do_lap = r_pulse[1] & ~r_pulse[0] & ~r_pulse[2];

    // State, lap register and registered Moore outputs.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state      <= S_IDLE;
            r_lap_q      <= '0;
            r_lap_active <= 1'b0;
            r_count      <= 1'b0;
            r_clear      <= 1'b0;
            r_running    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_lap_q      <= w_lap_q_nxt;
            r_lap_active <= w_lap_active_nxt;
            r_count      <= w_count_nxt;
            r_clear      <= w_clear_nxt;
            r_running    <= w_running_nxt;
        end
    end

    // Next state, lap handling, and outputs decoded from the next state so
    // they leave flops in step with the state register.
    always_comb begin
        w_state_nxt      = r_state;
        w_lap_q_nxt      = r_lap_q;
        w_lap_active_nxt = r_lap_active;
        w_count_nxt      = 1'b0;
        w_clear_nxt      = 1'b0;
        w_running_nxt    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_do_clr) begin
                    w_state_nxt = S_CLR_ARM;
                end else if (w_do_ss) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_do_clr) begin
                    w_state_nxt = S_CLR_FIRE;
                end else if (w_do_ss) begin
                    w_state_nxt = S_PAUSE;
                end else if (w_do_lap) begin
                    if (!r_lap_active) begin
                        w_lap_q_nxt      = bus.time_i;
                        w_lap_active_nxt = 1'b1;
                    end else begin
                        w_lap_active_nxt = 1'b0;
                    end
                end
            end
            S_PAUSE: begin
                if (w_do_clr) begin
                    w_state_nxt = S_CLR_ARM;
                end else if (w_do_ss) begin
                    w_state_nxt = S_RUN;
                end else if (w_do_lap) begin
                    w_lap_active_nxt = 1'b0;
                end
            end
            S_CLR_ARM: begin
                w_state_nxt = S_CLR_FIRE;
            end
            S_CLR_FIRE: begin
                w_state_nxt      = S_IDLE;
                w_lap_active_nxt = 1'b0;
            end
            default: begin
                w_state_nxt      = S_IDLE;
                w_lap_active_nxt = 1'b0;
            end
        endcase

        w_count_nxt   = (w_state_nxt == S_RUN) || (w_state_nxt == S_CLR_ARM);
        w_clear_nxt   = (w_state_nxt == S_CLR_FIRE);
        w_running_nxt = (w_state_nxt == S_RUN);
    end

    assign bus.count_o      = r_count;
    assign bus.clear_o      = r_clear;
    assign bus.running_o    = r_running;
    assign bus.lap_active_o = r_lap_active;
    assign bus.disp_o       = r_lap_active ? r_lap_q : bus.time_i;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: drives buttons against a small stopwatch counter
// model and compares controller outputs to a queue of expected cycles.
`timescale 1ns/1ps
module tb_stopwatch_ctrl;

    localparam int unsigned TIME_W = 8;
    localparam int          S      = 2;
    localparam int          D_TRK  = 2;   // disp must follow time_i
    localparam int          D_VAL  = 1;   // disp must equal a fixed value
    localparam logic [2:0]  B_SS   = 3'b001;
    localparam logic [2:0]  B_LAP  = 3'b010;
    localparam logic [2:0]  B_CLR  = 3'b100;

    typedef struct {
        string             tag;
        bit                cnt;
        bit                clr;
        bit                run;
        bit                lap;
        int                dm;
        logic [TIME_W-1:0] dv;
    } exp_t;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic [2:0]        btn   = 3'b000;   // {clear, lap, start_stop}
    logic              ld_req = 1'b0;
    logic [TIME_W-1:0] ld_val = '0;
    logic [TIME_W-1:0] m_time;
    logic              m_counting;
    logic [TIME_W-1:0] v_hold;
    int                n_chk  = 0;
    int                n_pass = 0;
    exp_t              sb[$];

    always #5 clk = ~clk;

    stopwatch_ctrl_if #(.TIME_W(TIME_W)) bus ();

    stopwatch_ctrl #(.TIME_W(TIME_W), .SYNC_STAGES(S)) dut (
        .clk_i    (clk),
        .reset_ni (rst_n),
        .bus      (bus)
    );

    assign bus.start_stop_i = btn[0];
    assign bus.lap_i        = btn[1];
    assign bus.clear_i      = btn[2];
    assign bus.time_i       = m_time;

    // Stopwatch counter model: counts only once already in its counting state,
    // honours clear only while counting; the bench may preload a value.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_time     <= '0;
            m_counting <= 1'b0;
        end else begin
            if (ld_req)                          m_time <= ld_val;
            else if (bus.clear_o && m_counting)  m_time <= '0;
            else if (bus.count_o && m_counting)  m_time <= m_time + 1'b1;
            m_counting <= bus.count_o;
        end
    end

    a_excl: assert property (@(posedge clk) disable iff (!rst_n) !(bus.count_o && bus.clear_o))
        else $error("FAIL count_clear_excl: count_o and clear_o both high");

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    function automatic void push(input string tag, input bit c, input bit k, input bit r,
                                 input bit l, input int dm, input logic [TIME_W-1:0] dv);
        exp_t e;
        e.tag = tag; e.cnt = c; e.clr = k; e.run = r; e.lap = l; e.dm = dm; e.dv = dv;
        sb.push_back(e);
    endfunction

    task automatic cmp_exp();
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        chk({e.tag, ".count"},   32'(bus.count_o),      32'(e.cnt));
        chk({e.tag, ".clear"},   32'(bus.clear_o),      32'(e.clr));
        chk({e.tag, ".running"}, 32'(bus.running_o),    32'(e.run));
        chk({e.tag, ".lap"},     32'(bus.lap_active_o), 32'(e.lap));
        if (e.dm == D_VAL)      chk({e.tag, ".disp"}, 32'(bus.disp_o), 32'(e.dv));
        else if (e.dm == D_TRK) chk({e.tag, ".disp"}, 32'(bus.disp_o), 32'(m_time));
    endtask

    // Press ma (optionally releasing reset / preloading the counter), add mb
    // 'off' cycles later, compare n queued cycles from edge S+1, then release.
    task automatic press(input logic [2:0] ma, input logic [2:0] mb, input int off,
                         input int n, input bit ld, input logic [TIME_W-1:0] lv,
                         input bit rel);
        @(negedge clk);
        btn    = ma;
        ld_req = ld;
        ld_val = lv;
        if (rel) rst_n = 1'b1;
        for (int j = 1; j <= S + n; j++) begin
            @(posedge clk); #1;
            ld_req = 1'b0;
            if (j == off) btn = btn | mb;
            if (j >= S + 1) cmp_exp();
        end
        btn = 3'b000;
        repeat (S + 3) @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with all buttons held.
        btn = 3'b111;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.count",   32'(bus.count_o),      32'd0);
        chk("rst.clear",   32'(bus.clear_o),      32'd0);
        chk("rst.running", 32'(bus.running_o),    32'd0);
        chk("rst.lap",     32'(bus.lap_active_o), 32'd0);
        chk("rst.disp",    32'(bus.disp_o),       32'd0);

        // Release with buttons held: clear wins, one pulse each.
        push("rel.idle", 0, 0, 0, 0, D_TRK, '0);
        push("rel.arm",  1, 0, 0, 0, D_TRK, '0);
        push("rel.fire", 0, 1, 0, 0, D_TRK, '0);
        push("rel.done", 0, 0, 0, 0, D_VAL, '0);
        push("rel.hold", 0, 0, 0, 0, D_VAL, '0);
        push("rel.hold", 0, 0, 0, 0, D_VAL, '0);
        press(3'b111, 3'b000, 0, 6, 1'b0, '0, 1'b1);

        // Start, pause, resume.
        push("ss1.pre", 0, 0, 0, 0, D_TRK, '0);
        push("ss1.run", 1, 0, 1, 0, D_TRK, '0);
        push("ss1.run", 1, 0, 1, 0, D_TRK, '0);
        press(B_SS, 3'b000, 0, 3, 1'b0, '0, 1'b0);
        push("ss2.pre",   1, 0, 1, 0, D_TRK, '0);
        push("ss2.pause", 0, 0, 0, 0, D_TRK, '0);
        press(B_SS, 3'b000, 0, 2, 1'b0, '0, 1'b0);
        v_hold = m_time;
        repeat (4) @(posedge clk);
        #1;
        chk("pause.hold_disp", 32'(bus.disp_o), 32'(v_hold));
        push("ss3.pre", 0, 0, 0, 0, D_VAL, v_hold);
        push("ss3.run", 1, 0, 1, 0, D_TRK, '0);
        push("ss3.run", 1, 0, 1, 0, D_TRK, '0);
        press(B_SS, 3'b000, 0, 3, 1'b0, '0, 1'b0);

        // Lap freeze at 37 while running, then unfreeze.
        push("lap1.pre",    1, 0, 1, 0, D_TRK, '0);
        push("lap1.frz",    1, 0, 1, 1, D_VAL, 8'd37);
        push("lap1.frz",    1, 0, 1, 1, D_VAL, 8'd37);
        push("lap1.frz",    1, 0, 1, 1, D_VAL, 8'd37);
        push("lap1.frz",    1, 0, 1, 1, D_VAL, 8'd37);
        press(B_LAP, 3'b000, 0, 5, 1'b1, 8'(37 - S), 1'b0);
        push("lap2.pre",    1, 0, 1, 1, D_VAL, 8'd37);
        push("lap2.unfrz",  1, 0, 1, 0, D_TRK, '0);
        press(B_LAP, 3'b000, 0, 2, 1'b0, '0, 1'b0);
        push("lap3.pre",    1, 0, 1, 0, D_TRK, '0);
        push("lap3.frz",    1, 0, 1, 1, D_VAL, 8'd50);
        press(B_LAP, 3'b000, 0, 2, 1'b1, 8'(50 - S), 1'b0);
        push("lap4.pre",    1, 0, 1, 1, D_VAL, 8'd50);
        push("lap4.pause",  0, 0, 0, 1, D_VAL, 8'd50);
        press(B_SS, 3'b000, 0, 2, 1'b0, '0, 1'b0);
        push("lap5.pre",    0, 0, 0, 1, D_VAL, 8'd50);
        push("lap5.unfrz",  0, 0, 0, 0, D_TRK, '0);
        press(B_LAP, 3'b000, 0, 2, 1'b0, '0, 1'b0);
        push("lap6.nocap",  0, 0, 0, 0, D_TRK, '0);
        push("lap6.nocap",  0, 0, 0, 0, D_TRK, '0);
        push("lap6.nocap",  0, 0, 0, 0, D_TRK, '0);
        press(B_LAP, 3'b000, 0, 3, 1'b0, '0, 1'b0);

        // Clear from PAUSE at 100: arm, fire, counter reads 0.
        push("clrp.pre",  0, 0, 0, 0, D_VAL, 8'd100);
        push("clrp.arm",  1, 0, 0, 0, D_VAL, 8'd100);
        push("clrp.fire", 0, 1, 0, 0, D_VAL, 8'd100);
        push("clrp.idle", 0, 0, 0, 0, D_VAL, 8'd0);
        push("clrp.idle", 0, 0, 0, 0, D_VAL, 8'd0);
        press(B_CLR, 3'b000, 0, 5, 1'b1, 8'd100, 1'b0);

        // Clear from RUN: straight to fire.
        push("run.pre", 0, 0, 0, 0, D_TRK, '0);
        push("run.on",  1, 0, 1, 0, D_TRK, '0);
        press(B_SS, 3'b000, 0, 2, 1'b0, '0, 1'b0);
        push("clrr.pre",  1, 0, 1, 0, D_TRK, '0);
        push("clrr.fire", 0, 1, 0, 0, D_TRK, '0);
        push("clrr.idle", 0, 0, 0, 0, D_VAL, 8'd0);
        press(B_CLR, 3'b000, 0, 3, 1'b0, '0, 1'b0);

        // All three at once in RUN with lap frozen: clear only, lap_q kept.
        push("run2.pre", 0, 0, 0, 0, D_TRK, '0);
        push("run2.on",  1, 0, 1, 0, D_TRK, '0);
        press(B_SS, 3'b000, 0, 2, 1'b0, '0, 1'b0);
        push("lap7.pre", 1, 0, 1, 0, D_TRK, '0);
        push("lap7.frz", 1, 0, 1, 1, D_VAL, 8'd20);
        press(B_LAP, 3'b000, 0, 2, 1'b1, 8'(20 - S), 1'b0);
        push("all.pre",  1, 0, 1, 1, D_VAL, 8'd20);
        push("all.fire", 0, 1, 0, 1, D_VAL, 8'd20);
        push("all.idle", 0, 0, 0, 0, D_VAL, 8'd0);
        push("all.idle", 0, 0, 0, 0, D_VAL, 8'd0);
        press(3'b111, 3'b000, 0, 4, 1'b0, '0, 1'b0);

        // Start/stop landing in CLR_ARM, then in CLR_FIRE: ignored.
        for (int off = 1; off <= 2; off++) begin
            push("ign.pre",  0, 0, 0, 0, D_TRK, '0);
            push("ign.arm",  1, 0, 0, 0, D_TRK, '0);
            push("ign.fire", 0, 1, 0, 0, D_TRK, '0);
            push("ign.idle", 0, 0, 0, 0, D_VAL, 8'd0);
            push("ign.idle", 0, 0, 0, 0, D_VAL, 8'd0);
            push("ign.idle", 0, 0, 0, 0, D_VAL, 8'd0);
            press(B_CLR, B_SS, off, 6, 1'b0, '0, 1'b0);
        end

        // Async reset in CLR_ARM: outputs drop without a clock, no clear later.
        @(negedge clk);
        btn = B_CLR;
        repeat (S + 2) @(posedge clk);
        #1;
        push("areset.arm", 1, 0, 0, 0, D_TRK, '0);
        cmp_exp();
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset.count",   32'(bus.count_o),   32'd0);
        chk("areset.clear",   32'(bus.clear_o),   32'd0);
        chk("areset.running", 32'(bus.running_o), 32'd0);
        btn = 3'b000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            chk("post_rst.clear", 32'(bus.clear_o), 32'd0);
            chk("post_rst.count", 32'(bus.count_o), 32'd0);
        end

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
